// File: rtl/delay_timer_ctrl.sv
// delay_timer_ctrl
// Programmable delay sequencer shared by the MOVR, MOVRHS and PAUSE paths
// of the stepper-motor control FSM. The system clock is prescaled into
// delay ticks. A loaded tick count is then counted down, and completion is
// reported on delay_done.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                synchronous, active-high reset
//   start_delay_counter  load delay_value and begin a new delay (level-sampled)
//   enable_delay_counter advance the delay while high, freeze while low
//   delay_value          delay length in ticks, sampled on start
//   delay_done           high while in DONE
//   busy                 high while in COUNT
//   remaining            ticks left in the current delay
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no delay active, waiting for start
// ST_COUNT | delay running; ticks advance only while enable is high
// ST_DONE  | delay expired; held until enable drops
module delay_timer_ctrl #(
    parameter int PRESCALE   = 50000,
    parameter int PRESCALE_W = 16,
    parameter int DELAY_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_delay_counter,
    input  logic               enable_delay_counter,
    input  logic [DELAY_W-1:0] delay_value,
    output logic               delay_done,
    output logic               busy,
    output logic [DELAY_W-1:0] remaining
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Last prescale value before a tick. PRESCALE may equal 2^PRESCALE_W,
    // so this is formed from PRESCALE-1, which always fits.
    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);

    state_t                state, state_nxt;
    logic [PRESCALE_W-1:0] prescale, prescale_nxt;
    logic [DELAY_W-1:0]    rem, rem_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            prescale <= '0;
            rem      <= '0;
        end else begin
            state    <= state_nxt;
            prescale <= prescale_nxt;
            rem      <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        prescale_nxt = prescale;
        rem_nxt      = rem;
        // Start has priority over enable and completion, in every state.
        if (start_delay_counter) begin
            rem_nxt      = delay_value;
            prescale_nxt = '0;
            state_nxt    = (delay_value == '0) ? ST_DONE : ST_COUNT;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_COUNT: begin
                    if (enable_delay_counter) begin
                        if (prescale == PRESCALE_LAST) begin
                            prescale_nxt = '0;
                            rem_nxt      = rem - DELAY_W'(1);
                            if (rem == DELAY_W'(1)) begin
                                state_nxt = ST_DONE;
                            end
                        end else begin
                            prescale_nxt = prescale + PRESCALE_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!enable_delay_counter) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // DONE is only entered with rem already 0, so remaining reads 0 there.
    assign delay_done = (state == ST_DONE);
    assign busy       = (state == ST_COUNT);
    assign remaining  = rem;

endmodule
